// File: rtl/ram32x3_reader.sv
// -----------------------------------------------------------------------------
// ram32x3_reader
//
// Scans a 32 x 3-bit synchronous RAM from address 0 up to LAST_ADDR and
// presents each word, together with its address, on a valid/ready output.
// Each word takes three phases. ISSUE drives the address. WAIT covers the RAM
// read latency. HOLD presents the captured word until the consumer accepts it.
// With loop=1 the scan wraps to address 0 after LAST_ADDR and runs until stop.
// A scan that ends without wrapping emits a one-cycle done pulse.
//
// Parameters
//   RD_LATENCY  cycles from rd_addr presented to rd_data valid (1 or 2)
//   LAST_ADDR   final address of a scan (0..31)
//
// Ports
//   clock      single clock, all logic on posedge
//   reset_n    asynchronous active-low reset
//   start      begin a scan (sampled only while idle)
//   loop       wrap to 0 after LAST_ADDR (sampled at the last-address beat)
//   stop       abort the scan and return to idle
//   rd_addr    RAM read address
//   rd_data    RAM read data
//   out_addr   address of the word on out_data
//   out_data   captured RAM word
//   out_valid  out_addr/out_data valid (registered)
//   out_ready  consumer accepts the word when out_valid && out_ready
//   busy       high whenever not idle
//   done       one-cycle pulse when a non-looping scan completes
// -----------------------------------------------------------------------------
module ram32x3_reader #(
    parameter int RD_LATENCY = 1,
    parameter int LAST_ADDR  = 31
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       loop,
    input  logic       stop,
    output logic [4:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic [4:0] out_addr,
    output logic [2:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_FIN
    } state_t;

    localparam logic [4:0] LAST      = 5'(LAST_ADDR);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t     state_q,     state_d;
    logic [4:0] cnt_q,       cnt_d;
    logic [1:0] wait_q,      wait_d;
    logic [4:0] rd_addr_q,   rd_addr_d;
    logic [4:0] out_addr_q,  out_addr_d;
    logic [2:0] out_data_q,  out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q,      done_d;

    logic       handshake;

    // out_valid is a flop, so the handshake never feeds out_ready back
    // combinationally into out_valid.
    assign handshake = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                // start together with stop leaves the block idle.
                if (start && !stop) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                // rd_data belongs to rd_addr in the last WAIT cycle.
                if (wait_q == WAIT_LAST) begin
                    out_data_d = rd_data;
                    out_addr_d = cnt_q;
                    wait_d     = '0;
                    state_d    = ST_HOLD;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (cnt_q < LAST) begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = ST_ISSUE;
                    end else if (loop) begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop beats every other transition. A word that is accepted in the
        // same cycle still counts as delivered, but the scan ends here.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            wait_d  = '0;
        end

        // The address register loads only on entry to ISSUE. It stays fixed
        // through WAIT and keeps its last value after that.
        rd_addr_d   = (state_d == ST_ISSUE) ? cnt_d : rd_addr_q;
        out_valid_d = (state_d == ST_HOLD);
        done_d      = (state_d == ST_FIN);
    end

    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rd_addr_q   <= rd_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram32x3_reader.sv
// -----------------------------------------------------------------------------
// tb_ram32x3_reader
//
// Testbench for ram32x3_reader with three instances:
//   0: RD_LATENCY=1, LAST_ADDR=31
//   1: RD_LATENCY=2, LAST_ADDR=31
//   2: RD_LATENCY=1, LAST_ADDR=3
// Each instance reads a RAM model that holds word[a] = a mod 8 and has the
// matching read latency. Expected beats go into a queue when a scan starts.
// They are popped and compared as the DUT delivers words.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ram32x3_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       start_v   [3];
    logic       loop_v    [3];
    logic       stop_v    [3];
    logic       ready_v   [3];
    logic [4:0] rd_addr_v [3];
    logic [4:0] out_addr_v[3];
    logic [2:0] out_data_v[3];
    logic       out_valid_v[3];
    logic       busy_v    [3];
    logic       done_v    [3];

    logic [2:0] ram0_q, ram1_p, ram1_q, ram2_q;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] addr;
        logic [2:0] data;
    } beat_t;

    beat_t exp_q[$];

    // RAM models: word[a] = low three address bits. Instance 1 needs two
    // pipeline stages.
    always @(posedge clock) begin
        ram0_q <= rd_addr_v[0][2:0];
        ram1_p <= rd_addr_v[1][2:0];
        ram1_q <= ram1_p;
        ram2_q <= rd_addr_v[2][2:0];
    end

    ram32x3_reader #(.RD_LATENCY(1), .LAST_ADDR(31)) u_lat1 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .loop(loop_v[0]),
        .stop(stop_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(ram0_q),
        .out_addr(out_addr_v[0]), .out_data(out_data_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(ready_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    ram32x3_reader #(.RD_LATENCY(2), .LAST_ADDR(31)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .loop(loop_v[1]),
        .stop(stop_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(ram1_q),
        .out_addr(out_addr_v[1]), .out_data(out_data_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(ready_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    ram32x3_reader #(.RD_LATENCY(1), .LAST_ADDR(3)) u_last3 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .loop(loop_v[2]),
        .stop(stop_v[2]), .rd_addr(rd_addr_v[2]), .rd_data(ram2_q),
        .out_addr(out_addr_v[2]), .out_data(out_data_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(ready_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    // All outputs of one instance packed into one vector.
    function automatic logic [15:0] outs(input int i);
        return {rd_addr_v[i], out_addr_v[i], out_data_v[i],
                out_valid_v[i], busy_v[i], done_v[i]};
    endfunction

    // Runs one scan on instance idx and scores every beat against the queue.
    // With use_loop, a stop is raised together with the last expected beat.
    // restart_cyc > 0 pulses start again at that cycle of the scan.
    task automatic run_scan(input int idx, input int n_beats, input bit use_loop,
                            input int restart_cyc, input string name);
        int    spacing;
        int    last;
        int    cyc;
        int    last_beat;
        int    done_cnt;
        bit    finished;
        beat_t e;
        spacing = (idx == 1) ? 4 : 3;
        last    = (idx == 2) ? 3 : 31;
        exp_q.delete();
        for (int b = 0; b < n_beats; b++) begin
            e.addr = 5'(b % (last + 1));
            e.data = 3'((b % (last + 1)) % 8);
            exp_q.push_back(e);
        end
        @(negedge clock);
        ready_v[idx] = 1'b1;
        loop_v[idx]  = use_loop;
        start_v[idx] = 1'b1;
        cyc = 0; last_beat = 0; done_cnt = 0; finished = 1'b0;
        while (!finished && cyc < 400) begin
            @(negedge clock);
            cyc++;
            start_v[idx] = (restart_cyc > 0 && cyc == restart_cyc);
            if (done_v[idx]) begin
                done_cnt++;
                checks++;
                if (exp_q.size() != 0 || cyc != last_beat + 1) begin
                    failures++;
                    $display("FAIL %s done_timing: got done at cycle %0d with %0d beats pending, expected cycle %0d with 0 pending",
                             name, cyc, exp_q.size(), last_beat + 1);
                end
                @(negedge clock);
                checks++;
                if ({busy_v[idx], done_v[idx]} !== 2'b00) begin
                    failures++;
                    $display("FAIL %s after_done: got busy=%b done=%b, expected busy=0 done=0",
                             name, busy_v[idx], done_v[idx]);
                end
                finished = 1'b1;
            end else if (out_valid_v[idx]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_beat: got beat addr=%0d at cycle %0d, expected no more beats",
                             name, out_addr_v[idx], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_addr_v[idx], out_data_v[idx], rd_addr_v[idx]} !== {e.addr, e.data, e.addr}) begin
                        failures++;
                        $display("FAIL %s beat: got addr=%0d data=%0d rd_addr=%0d, expected addr=%0d data=%0d rd_addr=%0d",
                                 name, out_addr_v[idx], out_data_v[idx], rd_addr_v[idx], e.addr, e.data, e.addr);
                    end
                    checks++;
                    if (cyc - last_beat != spacing) begin
                        failures++;
                        $display("FAIL %s spacing: got %0d cycles before addr=%0d, expected %0d",
                                 name, cyc - last_beat, e.addr, spacing);
                    end
                end
                last_beat = cyc;
                if (use_loop && exp_q.size() == 0) begin
                    // The last beat is accepted in the same cycle as stop.
                    stop_v[idx] = 1'b1;
                    @(negedge clock);
                    stop_v[idx] = 1'b0;
                    checks++;
                    if ({out_valid_v[idx], busy_v[idx], done_v[idx]} !== 3'b000) begin
                        failures++;
                        $display("FAIL %s stop: got valid=%b busy=%b done=%b, expected all 0",
                                 name, out_valid_v[idx], busy_v[idx], done_v[idx]);
                    end
                    finished = 1'b1;
                end
            end
        end
        start_v[idx] = 1'b0;
        loop_v[idx]  = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout: got %0d beats pending after %0d cycles, expected scan end",
                     name, exp_q.size(), cyc);
        end
        checks++;
        if (done_cnt != (use_loop ? 0 : 1)) begin
            failures++;
            $display("FAIL %s done_count: got %0d, expected %0d", name, done_cnt, use_loop ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; loop_v[i] = 1'b0; stop_v[i] = 1'b0; ready_v[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs(i) !== 16'h0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got %h, expected 0000", i, outs(i));
            end
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (outs(0) !== 16'h0) begin
            failures++;
            $display("FAIL idle_after_reset: got %h, expected 0000", outs(0));
        end
    endtask

    task automatic test_start_stop_idle();
        bit bad = 1'b0;
        @(negedge clock);
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        @(negedge clock);
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        repeat (3) begin
            if (busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) bad = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL start_stop_idle: got busy or valid high, expected idle");
        end
    endtask

    task automatic test_backpressure();
        int  n;
        bit  seen;
        bit  bad;
        @(negedge clock);
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clock);
            start_v[0] = 1'b0;
            n++;
            if (out_valid_v[0] && out_addr_v[0] == 5'd4) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_reach_addr4: got no beat at addr 4 within %0d cycles, expected one", n);
        end
        ready_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if ({out_valid_v[0], out_addr_v[0], out_data_v[0]} !== {1'b1, 5'd4, 3'd4}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b addr=%0d data=%0d, expected valid=1 addr=4 data=4",
                         i, out_valid_v[0], out_addr_v[0], out_data_v[0]);
            end
        end
        ready_v[0] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 6) begin
            @(negedge clock);
            n++;
            if (out_valid_v[0]) seen = 1'b1;
        end
        checks++;
        if (n != 3 || {out_addr_v[0], out_data_v[0]} !== {5'd5, 3'd5}) begin
            failures++;
            $display("FAIL bp_next_beat: got addr=%0d data=%0d after %0d cycles, expected addr=5 data=5 after 3",
                     out_addr_v[0], out_data_v[0], n);
        end
        // Abort with the word for address 5 still pending.
        ready_v[0] = 1'b0;
        stop_v[0]  = 1'b1;
        @(negedge clock);
        stop_v[0]  = 1'b0;
        ready_v[0] = 1'b1;
        checks++;
        if ({out_valid_v[0], busy_v[0], done_v[0]} !== 3'b000) begin
            failures++;
            $display("FAIL bp_stop: got valid=%b busy=%b done=%b, expected all 0",
                     out_valid_v[0], busy_v[0], done_v[0]);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_after_stop: got done or busy high, expected idle with no done");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        bit saw_done;
        @(negedge clock);
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        n = 0; seen = 1'b0; saw_done = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            start_v[0] = 1'b0;
            n++;
            if (done_v[0]) saw_done = 1'b1;
            if (out_valid_v[0] && out_addr_v[0] == 5'd10) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_mid_reach: got no beat at addr 10 within %0d cycles, expected one", n);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs(0) !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_async: got %h, expected 0000", outs(0));
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (done_v[0]) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_idle: got done_seen=%b busy=%b, expected done_seen=0 busy=0",
                     saw_done, busy_v[0]);
        end
        run_scan(0, 32, 1'b0, 0, "rst_restart");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        run_scan(0, 32, 1'b0, 0, "full_scan_l1");
        test_start_stop_idle();
        test_backpressure();
        run_scan(2, 10, 1'b1, 0, "loop_last3");
        run_scan(2, 4, 1'b0, 0, "short_scan_last3");
        run_scan(1, 32, 1'b0, 0, "full_scan_l2");
        test_reset_mid();
        run_scan(0, 32, 1'b0, 20, "start_during_scan");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
